pe_scatter_unit: RTL and testbench
==================================

PE_SCATTER_UNIT -- requirements
Module: pe_scatter_unit

Interface
REQ-001 Parameter PE_ELEMENTS, default 4: number of PE lanes; SHALL be a power of two, 2 or greater.
REQ-002 Parameter DATA_LEN, default 32: lane data width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rstn  input  1  reset; asynchronous, active-low.
REQ-005 in_data  input  DATA_LEN  scalar word from the upstream stream.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  unit accepts in_data this cycle.
REQ-008 in_bcast  input  1  broadcast request, qualified with in_valid.
REQ-009 pe_in  output  DATA_LEN x PE_ELEMENTS  unpacked lane vector to the PEs.
REQ-010 pe_valid  output  1  pe_in holds a complete vector.
REQ-011 pe_ready  input  1  PEs consume the vector this cycle.
REQ-012 fill_cnt  output  $clog2(PE_ELEMENTS)+1  number of lanes written in the current vector.

Function
REQ-013 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when pe_valid && pe_ready.
REQ-014 States: IDLE (fill_cnt=0), FILL (0<fill_cnt<PE_ELEMENTS), FULL (pe_valid=1, fill_cnt=PE_ELEMENTS).
REQ-015 in_ready = (state != FULL) || pe_ready; it SHALL be combinational only on pe_ready.
REQ-016 In IDLE or FILL, an input transfer SHALL write in_data to lane fill_cnt and increment fill_cnt; the first word of a vector goes to lane 0.
REQ-017 When the word written is the one for lane PE_ELEMENTS-1, the next state SHALL be FULL and pe_valid SHALL be 1 in the next cycle (latency 1 cycle from the last accepted word).
REQ-018 An input transfer in IDLE with in_bcast=1 SHALL write in_data to all lanes and go to FULL in the next cycle.
REQ-019 in_bcast SHALL be ignored when fill_cnt != 0, and the word SHALL be stored as a normal lane write.
REQ-020 In FULL, pe_in and pe_valid SHALL hold stable until an output transfer occurs.
REQ-021 FULL with an output transfer and no input transfer SHALL go to IDLE with fill_cnt=0.
REQ-022 FULL with simultaneous output and input transfers SHALL start the next vector: lane 0 = in_data, fill_cnt=1, state FILL. With in_bcast=1, all lanes = in_data and the state SHALL stay FULL.
REQ-023 Lanes not yet written in FILL SHALL retain their previous values; only pe_valid qualifies pe_in.
REQ-024 Sustained throughput SHALL be one word per cycle with no bubble between vectors while pe_ready=1.

Reset
REQ-025 On rstn low, the unit SHALL asynchronously clear all pe_in lanes to 0, pe_valid to 0, fill_cnt to 0, and the state to IDLE.
REQ-026 in_ready SHALL be 1 on the first cycle after rstn deasserts.
REQ-027 Reset mid-vector or in FULL SHALL discard the partial or pending vector without emitting it.

Configuration
REQ-028 Macro SCATTER_FLUSH_EN defined: an extra input port flush (1 bit) SHALL exist.
REQ-029 flush behaviour in FILL: remaining lanes SHALL be zero-filled and the unit SHALL go to FULL next cycle. A word accepted in the same cycle SHALL be written before the padding.
REQ-030 flush behaviour in IDLE or FULL: it SHALL have no effect.
REQ-031 Macro SCATTER_FLUSH_EN undefined: the flush port SHALL be absent and partial vectors SHALL complete only by filling all lanes.

Verification
REQ-032 PE_ELEMENTS=4, pe_ready=1, words 1,2,3,4 on consecutive cycles -> pe_valid=1 one cycle after word 4, pe_in={1,2,3,4} lanes 0..3.
REQ-033 Idle unit, in_data=0xA5 with in_bcast=1 -> next cycle pe_valid=1 and all four lanes = 0xA5.
REQ-034 FULL with pe_ready=0 for 5 cycles, in_valid=1 -> in_ready=0 and pe_in stable; pe_ready=1 with in_data=9 -> vector consumed, lane 0=9, fill_cnt=1.
REQ-035 Words 7,8 followed by in_bcast=1 on word 9 -> broadcast ignored, lane 2=9, fill_cnt=3.
REQ-036 rstn pulsed low after 2 of 4 words -> pe_valid=0, fill_cnt=0, all lanes 0; the next 4 words form a fresh vector.
REQ-037 With SCATTER_FLUSH_EN defined: words 5,6 then flush -> pe_in={5,6,0,0}, pe_valid=1 the next cycle.

Source files
------------

// File: rtl/pe_scatter_if.sv
// Upstream word stream and PE lane-vector bus for pe_scatter_unit.
// The flush input exists only when SCATTER_FLUSH_EN is defined.
interface pe_scatter_if #(
  parameter int unsigned PE_ELEMENTS = 4,
  parameter int unsigned DATA_LEN    = 32
);
  localparam int unsigned CW = $clog2(PE_ELEMENTS) + 1;

  logic [DATA_LEN-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic                in_bcast;
  logic [DATA_LEN-1:0] pe_in [PE_ELEMENTS];
  logic                pe_valid;
  logic                pe_ready;
  logic [CW-1:0]       fill_cnt;
`ifdef SCATTER_FLUSH_EN
  logic                flush;
`endif

  // Source/sink side driving the stream and consuming vectors
  modport master (
    output in_data, in_valid, in_bcast, pe_ready,
`ifdef SCATTER_FLUSH_EN
    output flush,
`endif
    input  in_ready, pe_in, pe_valid, fill_cnt
  );

  // Scatter unit side
  modport slave (
    input  in_data, in_valid, in_bcast, pe_ready,
`ifdef SCATTER_FLUSH_EN
    input  flush,
`endif
    output in_ready, pe_in, pe_valid, fill_cnt
  );
endinterface

// File: rtl/pe_scatter_unit.sv
// Scatters a scalar word stream into a PE_ELEMENTS-wide lane vector, with broadcast.
// Optional SCATTER_FLUSH_EN adds a flush input that zero-pads a partial vector.
module pe_scatter_unit #(
  parameter int unsigned PE_ELEMENTS = 4,
  parameter int unsigned DATA_LEN    = 32
) (
  input  logic          clk,
  input  logic          rstn,
  pe_scatter_if.slave   bus
);
  localparam int unsigned LW = $clog2(PE_ELEMENTS);
  localparam int unsigned CW = LW + 1;

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       fill_q, fill_d;
  logic [DATA_LEN-1:0] lanes_q [PE_ELEMENTS];
  logic [DATA_LEN-1:0] lanes_d [PE_ELEMENTS];
  logic                valid_q, valid_d;
  logic                in_xfer, out_xfer, last_lane;
`ifdef SCATTER_FLUSH_EN
  logic [CW-1:0]       pad_start;
`endif

  // Ready depends combinationally only on pe_ready; the rest is registered state
  assign bus.in_ready = (state_q != FULL) || bus.pe_ready;
  assign in_xfer      = bus.in_valid && bus.in_ready;
  assign out_xfer     = valid_q && bus.pe_ready;
  assign last_lane    = (fill_q == CW'(PE_ELEMENTS - 1));

  assign bus.pe_valid = valid_q;
  assign bus.fill_cnt = fill_q;
  assign bus.pe_in    = lanes_q;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    lanes_d = lanes_q;
    valid_d = valid_q;
`ifdef SCATTER_FLUSH_EN
    pad_start = fill_q + CW'(in_xfer);
`endif
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          if (bus.in_bcast) begin
            for (int i = 0; i < PE_ELEMENTS; i++) lanes_d[i] = bus.in_data;
            fill_d  = CW'(PE_ELEMENTS);
            valid_d = 1'b1;
            state_d = FULL;
          end else begin
            lanes_d[0] = bus.in_data;
            fill_d     = CW'(1);
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        // Broadcast is ignored mid-vector; the word lands in the next lane
        if (in_xfer) begin
          lanes_d[fill_q[LW-1:0]] = bus.in_data;
          fill_d = fill_q + CW'(1);
          if (last_lane) begin
            valid_d = 1'b1;
            state_d = FULL;
          end
        end
`ifdef SCATTER_FLUSH_EN
        if (bus.flush) begin
          for (int i = 0; i < PE_ELEMENTS; i++)
            if (CW'(i) >= pad_start) lanes_d[i] = '0;
          fill_d  = CW'(PE_ELEMENTS);
          valid_d = 1'b1;
          state_d = FULL;
        end
`endif
      end
      FULL: begin
        if (out_xfer) begin
          if (in_xfer && bus.in_bcast) begin
            for (int i = 0; i < PE_ELEMENTS; i++) lanes_d[i] = bus.in_data;
            fill_d = CW'(PE_ELEMENTS);
          end else if (in_xfer) begin
            lanes_d[0] = bus.in_data;
            fill_d     = CW'(1);
            valid_d    = 1'b0;
            state_d    = FILL;
          end else begin
            fill_d  = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        fill_d  = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      fill_q  <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < PE_ELEMENTS; i++) lanes_q[i] <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      lanes_q <= lanes_d;
    end
  end
endmodule

// File: tb/tb_pe_scatter_unit.sv
// Directed self-checking bench for pe_scatter_unit (PE_ELEMENTS=4, DATA_LEN=32).
// The flush case is compiled in only when SCATTER_FLUSH_EN is defined.
module tb_pe_scatter_unit;
  logic clk = 1'b0;
  logic rstn;
  int   compared = 0;
  int   mismatched = 0;

  pe_scatter_if #(.PE_ELEMENTS(4), .DATA_LEN(32)) bus ();

  pe_scatter_unit #(.PE_ELEMENTS(4), .DATA_LEN(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [31:0] l0, input logic [31:0] l1,
                           input logic [31:0] l2, input logic [31:0] l3);
    check({tag, " lane0"}, bus.pe_in[0], l0);
    check({tag, " lane1"}, bus.pe_in[1], l1);
    check({tag, " lane2"}, bus.pe_in[2], l2);
    check({tag, " lane3"}, bus.pe_in[3], l3);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic b);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_bcast = b;
    tick();
    bus.in_valid = 1'b0;
    bus.in_bcast = 1'b0;
  endtask

  initial begin
    rstn         = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_bcast = 1'b0;
    bus.pe_ready = 1'b0;
`ifdef SCATTER_FLUSH_EN
    bus.flush    = 1'b0;
`endif
    tick();
    check("rst pe_valid", 32'(bus.pe_valid), 32'd0);
    check("rst fill_cnt", 32'(bus.fill_cnt), 32'd0);
    check_vec("rst", 0, 0, 0, 0);
    rstn = 1'b1;
    tick();
    check("post-rst in_ready", 32'(bus.in_ready), 32'd1);

    // Four sequential words form one vector
    bus.pe_ready = 1'b1;
    send(1, 0);
    check("seq fill1", 32'(bus.fill_cnt), 32'd1);
    send(2, 0);
    send(3, 0);
    check("seq valid pre", 32'(bus.pe_valid), 32'd0);
    send(4, 0);
    check("seq pe_valid", 32'(bus.pe_valid), 32'd1);
    check("seq fill4", 32'(bus.fill_cnt), 32'd4);
    check_vec("seq", 1, 2, 3, 4);
    tick();
    check("drain pe_valid", 32'(bus.pe_valid), 32'd0);
    check("drain fill", 32'(bus.fill_cnt), 32'd0);

    // Broadcast from idle
    bus.pe_ready = 1'b0;
    send(32'hA5, 1);
    check("bcast pe_valid", 32'(bus.pe_valid), 32'd1);
    check_vec("bcast", 32'hA5, 32'hA5, 32'hA5, 32'hA5);

    // Backpressure hold in FULL, then simultaneous consume + new word
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h77;
    for (int c = 0; c < 5; c++) begin
      check("hold in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check("hold pe_valid", 32'(bus.pe_valid), 32'd1);
      check("hold lane2", bus.pe_in[2], 32'hA5);
    end
    bus.pe_ready = 1'b1;
    bus.in_data  = 9;
    #1;
    check("release in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("restart pe_valid", 32'(bus.pe_valid), 32'd0);
    check("restart fill", 32'(bus.fill_cnt), 32'd1);
    check_vec("restart retain", 9, 32'hA5, 32'hA5, 32'hA5);
    send(10, 0);
    send(11, 0);
    send(12, 0);
    check_vec("restart vec", 9, 10, 11, 12);
    tick();
    check("idle again", 32'(bus.fill_cnt), 32'd0);

    // Broadcast ignored mid-vector
    send(7, 0);
    send(8, 0);
    send(9, 1);
    check("bcast-ign fill", 32'(bus.fill_cnt), 32'd3);
    check("bcast-ign valid", 32'(bus.pe_valid), 32'd0);
    check_vec("bcast-ign", 7, 8, 9, 12);

    // Back-to-back vectors: broadcast during consume, then streaming with no bubble
    send(10, 0);
    check_vec("b2b first", 7, 8, 9, 10);
    send(20, 1);
    check("b2b bcast valid", 32'(bus.pe_valid), 32'd1);
    check_vec("b2b bcast", 20, 20, 20, 20);
    bus.in_valid = 1'b1;
    for (int w = 21; w <= 24; w++) begin
      bus.in_data = 32'(w);
      #1;
      check("b2b in_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    check("b2b valid", 32'(bus.pe_valid), 32'd1);
    check_vec("b2b stream", 21, 22, 23, 24);
    tick();

    // Reset mid-vector discards it
    send(1, 0);
    send(2, 0);
    rstn = 1'b0;
    #1;
    check("midrst fill", 32'(bus.fill_cnt), 32'd0);
    check("midrst valid", 32'(bus.pe_valid), 32'd0);
    check_vec("midrst", 0, 0, 0, 0);
    rstn = 1'b1;
    tick();
    send(5, 0);
    send(6, 0);
    send(7, 0);
    send(8, 0);
    check("fresh valid", 32'(bus.pe_valid), 32'd1);
    check_vec("fresh", 5, 6, 7, 8);

    // Reset while FULL and stalled discards the pending vector
    bus.pe_ready = 1'b0;
    tick();
    rstn = 1'b0;
    #1;
    check("fullrst valid", 32'(bus.pe_valid), 32'd0);
    check("fullrst lane0", bus.pe_in[0], 32'd0);
    rstn = 1'b1;
    tick();
    bus.pe_ready = 1'b1;

`ifdef SCATTER_FLUSH_EN
    // Flush in IDLE has no effect
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush idle valid", 32'(bus.pe_valid), 32'd0);
    send(5, 0);
    send(6, 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush valid", 32'(bus.pe_valid), 32'd1);
    check_vec("flush", 5, 6, 0, 0);
    tick();
    send(1, 0);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 3;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check_vec("flush+word", 1, 3, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
